// File: rtl/conv_tree_ser_pkg.sv
// -----------------------------------------------------------------------------
// conv_tree_ser_pkg
// Shared definitions for the multi-lane conv-tree serializer:
//   - ser_state_e : serializer FSM states (IDLE, SHIFT)
//   - ser_beats() : beats per word, including the optional parity beat
//   - ser_cfg_ok(): legality check for the INPUTS_NUM / LANES pair,
//                   evaluated at elaboration time by the top level
// Optional feature macro: CONV_TREE_SER_PARITY_EN (adds one parity beat/word).
// -----------------------------------------------------------------------------
package conv_tree_ser_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

`ifdef CONV_TREE_SER_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Beats needed to send one word: data beats plus the parity beat if enabled.
  function automatic int ser_beats(input int inputs_num, input int lanes);
    return (inputs_num / lanes) + (PARITY_EN ? 32'sd1 : 32'sd0);
  endfunction

  // Word must split into whole beats, and into at least two of them.
  function automatic bit ser_cfg_ok(input int inputs_num, input int lanes);
    return (lanes > 32'sd0) && ((inputs_num % lanes) == 32'sd0) &&
           ((inputs_num / lanes) >= 32'sd2);
  endfunction

endpackage

// File: rtl/conv_tree_ser_hold_buf.sv
// -----------------------------------------------------------------------------
// conv_tree_ser_hold_buf
// One-entry word + mode buffer that parks an accepted word while the shift
// register is still busy with the previous one.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   push_i            : capture data_i / msb_i this cycle
//   pop_i             : entry is consumed by the shift register this cycle
//   data_i, msb_i     : word and its bit order to store
//   full_o            : entry holds a word
//   data_o, msb_o     : stored word and bit order
//   ready_o           : registered "entry will be empty", low during reset
// -----------------------------------------------------------------------------
module conv_tree_ser_hold_buf
  import conv_tree_ser_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  input  logic         msb_i,
  output logic         full_o,
  output logic [W-1:0] data_o,
  output logic         msb_o,
  output logic         ready_o
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;
  logic         msb_q, msb_d;
  logic         ready_q;

  // Next entry contents; push and pop are never requested together because
  // a word is only accepted while the entry is empty.
  always_comb begin
    data_d = data_q;
    msb_d  = msb_q;
    if (push_i) begin
      full_d = 1'b1;
      data_d = data_i;
      msb_d  = msb_i;
    end else if (pop_i) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
  end

  // Entry registers; ready tracks the next-cycle empty state so it is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      data_q  <= {W{1'b0}};
      msb_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      full_q  <= full_d;
      data_q  <= data_d;
      msb_q   <= msb_d;
      ready_q <= !full_d;
    end
  end

  assign full_o  = full_q;
  assign data_o  = data_q;
  assign msb_o   = msb_q;
  assign ready_o = ready_q;

endmodule

// File: rtl/conv_tree_mlane_serializer.sv
// -----------------------------------------------------------------------------
// conv_tree_mlane_serializer
// Double-buffered parallel-to-serial converter: INPUTS_NUM-bit words arrive on
// a valid/ready handshake and leave LANES bits per beat, MSB- or LSB-first as
// selected per word. Back-to-back words stream with no idle beats.
// Ports:
//   CLK, RESET    : clock, asynchronous active-low reset
//   PAR_IN        : parallel word
//   PAR_VALID     : PAR_IN holds a valid word
//   MSB_FIRST     : order of the offered word (1 = MSB first)
//   PAR_READY     : registered; a word can be accepted this cycle
//   SERIAL_OUT    : current beat, slice bit i on lane i
//   SERIAL_VALID  : SERIAL_OUT carries word data
//   FRAME_START   : first beat of each word
// Optional feature macro: CONV_TREE_SER_PARITY_EN -- appends one beat per word
// carrying the even parity (XOR) of everything sent on each lane.
// -----------------------------------------------------------------------------
module conv_tree_mlane_serializer
  import conv_tree_ser_pkg::*;
#(
  parameter int INPUTS_NUM = 16,
  parameter int LANES      = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [INPUTS_NUM-1:0] PAR_IN,
  input  logic                  PAR_VALID,
  input  logic                  MSB_FIRST,
  output logic                  PAR_READY,
  output logic [LANES-1:0]      SERIAL_OUT,
  output logic                  SERIAL_VALID,
  output logic                  FRAME_START
);

  localparam int            BEATS    = ser_beats(INPUTS_NUM, LANES);
  localparam int            CW       = $clog2(BEATS);
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);
  localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  if (!ser_cfg_ok(INPUTS_NUM, LANES)) begin : g_bad_cfg
    $error("conv_tree_mlane_serializer: INPUTS_NUM must be a multiple of LANES with at least two beats");
  end

  logic                  hold_full_s, hold_msb_s, hold_ready_s;
  logic [INPUTS_NUM-1:0] hold_data_s;
  logic                  accept_s, sr_free_s, load_s, push_s, pop_s;
  logic [INPUTS_NUM-1:0] load_word_s;
  logic                  load_msb_s;
  logic [LANES-1:0]      data_slice_s;

  ser_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [INPUTS_NUM-1:0] sr_q, sr_d;
  logic                  sr_msb_q, sr_msb_d;
  logic [LANES-1:0]      out_q, out_d;
  logic                  valid_q, valid_d;
  logic                  frame_q, frame_d;
`ifdef CONV_TREE_SER_PARITY_EN
  logic [LANES-1:0]      par_q, par_d;
`endif

  conv_tree_ser_hold_buf #(
    .W (INPUTS_NUM)
  ) u_hold_buf (
    .clk     (CLK),
    .rst_n   (RESET),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  (PAR_IN),
    .msb_i   (MSB_FIRST),
    .full_o  (hold_full_s),
    .data_o  (hold_data_s),
    .msb_o   (hold_msb_s),
    .ready_o (hold_ready_s)
  );

  // Route an accepted word: straight into the shift register when it is free
  // (idle or on its last beat) and nothing is parked, otherwise park it.
  always_comb begin
    accept_s  = PAR_VALID && hold_ready_s;
    sr_free_s = (state_q == ST_IDLE) || (cnt_q == LAST_CNT);
    pop_s     = sr_free_s && hold_full_s;
    load_s    = sr_free_s && (hold_full_s || accept_s);
    push_s    = accept_s && !(sr_free_s && !hold_full_s);
    if (hold_full_s) begin
      load_word_s = hold_data_s;
      load_msb_s  = hold_msb_s;
    end else begin
      load_word_s = PAR_IN;
      load_msb_s  = MSB_FIRST;
    end
  end

  // The shift register moves toward the outgoing end, so the current beat is
  // always its top slice (MSB first) or bottom slice (LSB first).
  always_comb begin
    if (sr_msb_q) begin
      data_slice_s = sr_q[INPUTS_NUM-1 -: LANES];
    end else begin
      data_slice_s = sr_q[LANES-1:0];
    end
  end

  // FSM next state plus next values of the registered serial outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    sr_msb_d = sr_msb_q;
    out_d    = {LANES{1'b0}};
    valid_d  = 1'b0;
    frame_d  = 1'b0;
`ifdef CONV_TREE_SER_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (load_s) begin
          state_d  = ST_SHIFT;
          cnt_d    = ZERO_CNT;
          sr_d     = load_word_s;
          sr_msb_d = load_msb_s;
`ifdef CONV_TREE_SER_PARITY_EN
          par_d    = {LANES{1'b0}};
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        valid_d = 1'b1;
        frame_d = (cnt_q == ZERO_CNT);
`ifdef CONV_TREE_SER_PARITY_EN
        // Last beat is the parity beat; par_q already folds in every data beat.
        if (cnt_q == LAST_CNT) begin
          out_d = par_q;
        end else begin
          out_d = data_slice_s;
        end
        par_d = par_q ^ data_slice_s;
`else
        out_d = data_slice_s;
`endif
        if (load_s) begin
          state_d  = ST_SHIFT;
          cnt_d    = ZERO_CNT;
          sr_d     = load_word_s;
          sr_msb_d = load_msb_s;
`ifdef CONV_TREE_SER_PARITY_EN
          par_d    = {LANES{1'b0}};
`endif
        end else if (cnt_q == LAST_CNT) begin
          state_d = ST_IDLE;
          cnt_d   = ZERO_CNT;
        end else begin
          cnt_d = cnt_q + ONE_CNT;
          if (sr_msb_q) begin
            sr_d = sr_q << LANES;
          end else begin
            sr_d = sr_q >> LANES;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = ZERO_CNT;
      end
    endcase
  end

  // FSM state, datapath and registered outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= ZERO_CNT;
      sr_q     <= {INPUTS_NUM{1'b0}};
      sr_msb_q <= 1'b0;
      out_q    <= {LANES{1'b0}};
      valid_q  <= 1'b0;
      frame_q  <= 1'b0;
`ifdef CONV_TREE_SER_PARITY_EN
      par_q    <= {LANES{1'b0}};
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      sr_msb_q <= sr_msb_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      frame_q  <= frame_d;
`ifdef CONV_TREE_SER_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign PAR_READY    = hold_ready_s;
  assign SERIAL_OUT   = out_q;
  assign SERIAL_VALID = valid_q;
  assign FRAME_START  = frame_q;

endmodule

// File: tb/tb_conv_tree_mlane_serializer.sv
// -----------------------------------------------------------------------------
// tb_conv_tree_mlane_serializer
// Self-checking bench for conv_tree_mlane_serializer (INPUTS_NUM=16, LANES=2).
// The reference model is a queue of expected beats: an accepted word is
// expanded into its beats and appended; one beat leaves the queue per clock.
// The hold register is full whenever more than one word is still in the queue.
// Honours CONV_TREE_SER_PARITY_EN for the parity beat.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_conv_tree_mlane_serializer;

  localparam int IN_W = 16;
  localparam int LN   = 2;
`ifdef CONV_TREE_SER_PARITY_EN
  localparam int NBEATS = IN_W / LN + 1;
`else
  localparam int NBEATS = IN_W / LN;
`endif

  logic            CLK = 1'b0;
  logic            RESET;
  logic [IN_W-1:0] PAR_IN;
  logic            PAR_VALID;
  logic            MSB_FIRST;
  logic            PAR_READY;
  logic [LN-1:0]   SERIAL_OUT;
  logic            SERIAL_VALID;
  logic            FRAME_START;

  conv_tree_mlane_serializer #(
    .INPUTS_NUM (IN_W),
    .LANES      (LN)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PAR_IN       (PAR_IN),
    .PAR_VALID    (PAR_VALID),
    .MSB_FIRST    (MSB_FIRST),
    .PAR_READY    (PAR_READY),
    .SERIAL_OUT   (SERIAL_OUT),
    .SERIAL_VALID (SERIAL_VALID),
    .FRAME_START  (FRAME_START)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [LN-1:0] bits;
    logic          frame;
    int            id;
  } beat_t;

  beat_t      pend[$];
  int         next_id;
  logic       m_ready;
  logic [4:0] exp_vec;   // {ready, valid, frame, out[1:0]}
  logic       acc;
  int         n_checks;
  int         n_fail;

  function automatic logic [4:0] obs();
    return {PAR_READY, SERIAL_VALID, FRAME_START, SERIAL_OUT};
  endfunction

  function automatic int words_pending();
    if (pend.size() == 0) return 0;
    return pend[pend.size()-1].id - pend[0].id + 1;
  endfunction

  // Expand a word into its beats, in transmit order.
  task automatic enqueue_word(input logic [IN_W-1:0] w, input logic msb);
    beat_t           b;
    logic [IN_W-1:0] sh;
    for (int k = 0; k < IN_W / LN; k++) begin
      if (msb) sh = w >> (IN_W - LN * (k + 1));
      else     sh = w >> (LN * k);
      b.bits  = sh[LN-1:0];
      b.frame = (k == 0);
      b.id    = next_id;
      pend.push_back(b);
    end
`ifdef CONV_TREE_SER_PARITY_EN
    b.bits  = {^(w & 16'hAAAA), ^(w & 16'h5555)};
    b.frame = 1'b0;
    b.id    = next_id;
    pend.push_back(b);
`endif
    next_id++;
  endtask

  task automatic model_reset();
    pend.delete();
    m_ready = 1'b0;
    exp_vec = 5'b00000;
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model at the
  // rising edge, return at the next falling edge with exp_vec updated.
  task automatic step(input logic v, input logic [IN_W-1:0] w, input logic m);
    beat_t b;
    PAR_VALID = v;
    PAR_IN    = v ? w : IN_W'($urandom);
    MSB_FIRST = m;
    @(posedge CLK);
    acc = v && m_ready;
    if (pend.size() > 0) begin
      b = pend.pop_front();
      exp_vec[3:0] = {1'b1, b.frame, b.bits};
    end else begin
      exp_vec[3:0] = 4'b0000;
    end
    if (acc) enqueue_word(w, m);
    m_ready    = (words_pending() < 2);
    exp_vec[4] = m_ready;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET = 1'b0; PAR_VALID = 1'b0; PAR_IN = '0; MSB_FIRST = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    n_checks++;
    if (obs() !== 5'b00000) begin
      n_fail++; $display("FAIL reset_hold: got %b expected 00000", obs());
    end
    RESET = 1'b1;
    step(1'b0, '0, 1'b0);
    n_checks++;
    if (PAR_READY !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_release: got %b expected 1", PAR_READY);
    end
    n_checks++;
    if (obs() !== exp_vec) begin
      n_fail++; $display("FAIL reset_release: got %b expected %b", obs(), exp_vec);
    end
  endtask

  task automatic test_msb_first();
    logic [IN_W-1:0] seen = '0;
    int nvalid = 0;
    step(1'b1, 16'hC5AF, 1'b1);
    for (int c = 0; c < NBEATS + 4; c++) begin
      n_checks++;
      if (obs() !== exp_vec) begin
        n_fail++; $display("FAIL msb_first cycle %0d: got %b expected %b", c, obs(), exp_vec);
      end
      if (SERIAL_VALID === 1'b1) begin
        if (nvalid < IN_W / LN) seen = {seen[IN_W-LN-1:0], SERIAL_OUT};
        nvalid++;
      end
      step(1'b0, '0, 1'b0);
    end
    n_checks++;
    if (seen !== 16'hC5AF) begin
      n_fail++; $display("FAIL msb_first_beats: got %h expected c5af", seen);
    end
    n_checks++;
    if (nvalid != NBEATS) begin
      n_fail++; $display("FAIL msb_first_count: got %0d expected %0d", nvalid, NBEATS);
    end
  endtask

  task automatic test_lsb_first();
    logic [IN_W-1:0] seen = '0;
    int nvalid = 0;
    step(1'b1, 16'hC5AF, 1'b0);
    for (int c = 0; c < NBEATS + 4; c++) begin
      n_checks++;
      if (obs() !== exp_vec) begin
        n_fail++; $display("FAIL lsb_first cycle %0d: got %b expected %b", c, obs(), exp_vec);
      end
      if (SERIAL_VALID === 1'b1) begin
        if (nvalid < IN_W / LN) seen = {seen[IN_W-LN-1:0], SERIAL_OUT};
        nvalid++;
      end
      step(1'b0, '0, 1'b1);
    end
    n_checks++;
    if (seen !== 16'hFA53) begin
      n_fail++; $display("FAIL lsb_first_beats: got %h expected fa53", seen);
    end
  endtask

  task automatic test_back_to_back();
    int   nvalid = 0, nframe = 0;
    logic ready_low = 1'b0, ended = 1'b0, gap = 1'b0;
    step(1'b1, 16'hC5AF, 1'b1);
    n_checks++;
    if (obs() !== exp_vec) begin
      n_fail++; $display("FAIL b2b_first: got %b expected %b", obs(), exp_vec);
    end
    step(1'b1, 16'h0001, 1'b1);
    for (int c = 0; c < 2 * NBEATS + 4; c++) begin
      n_checks++;
      if (obs() !== exp_vec) begin
        n_fail++; $display("FAIL b2b cycle %0d: got %b expected %b", c, obs(), exp_vec);
      end
      if (PAR_READY === 1'b0) ready_low = 1'b1;
      if (SERIAL_VALID === 1'b1) begin
        if (ended) gap = 1'b1;
        nvalid++;
        if (FRAME_START === 1'b1) nframe++;
      end else if (nvalid > 0) begin
        ended = 1'b1;
      end
      step(1'b0, '0, 1'b0);
    end
    n_checks++;
    if (nvalid != 2 * NBEATS || gap) begin
      n_fail++; $display("FAIL b2b_contiguous: got %0d beats gap=%b expected %0d gap=0", nvalid, gap, 2 * NBEATS);
    end
    n_checks++;
    if (nframe != 2) begin
      n_fail++; $display("FAIL b2b_frames: got %0d expected 2", nframe);
    end
    n_checks++;
    if (!ready_low) begin
      n_fail++; $display("FAIL b2b_ready_drop: got ready never low expected a low cycle");
    end
  endtask

  task automatic test_reset_mid_word();
    int nvalid = 0;
    step(1'b1, 16'hC5AF, 1'b1);
    step(1'b1, 16'h1234, 1'b0);
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (obs() !== exp_vec) begin
        n_fail++; $display("FAIL midrst_pre cycle %0d: got %b expected %b", c, obs(), exp_vec);
      end
      step(1'b0, '0, 1'b0);
    end
    RESET = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 5'b00000) begin
      n_fail++; $display("FAIL midrst_immediate: got %b expected 00000", obs());
    end
    @(negedge CLK);
    n_checks++;
    if (obs() !== 5'b00000) begin
      n_fail++; $display("FAIL midrst_held: got %b expected 00000", obs());
    end
    RESET = 1'b1;
    model_reset();
    for (int c = 0; c < 2 * NBEATS; c++) begin
      step(1'b0, '0, 1'b0);
      n_checks++;
      if (obs() !== exp_vec) begin
        n_fail++; $display("FAIL midrst_post cycle %0d: got %b expected %b", c, obs(), exp_vec);
      end
      if (SERIAL_VALID === 1'b1) nvalid++;
    end
    n_checks++;
    if (nvalid != 0) begin
      n_fail++; $display("FAIL midrst_residual: got %0d beats expected 0", nvalid);
    end
  endtask

  task automatic test_stream();
    for (int c = 0; c < 60; c++) begin
      step(1'b1, IN_W'($urandom), 1'($urandom));
      n_checks++;
      if (obs() !== exp_vec) begin
        n_fail++; $display("FAIL stream cycle %0d: got %b expected %b", c, obs(), exp_vec);
      end
    end
    for (int c = 0; c < 2 * NBEATS + 4; c++) begin
      step(1'b0, '0, 1'b0);
      n_checks++;
      if (obs() !== exp_vec) begin
        n_fail++; $display("FAIL stream_drain cycle %0d: got %b expected %b", c, obs(), exp_vec);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(0, 99) < 70), IN_W'($urandom), 1'($urandom));
      n_checks++;
      if (obs() !== exp_vec) begin
        n_fail++; $display("FAIL random cycle %0d: got %b expected %b", c, obs(), exp_vec);
      end
    end
    for (int c = 0; c < 2 * NBEATS + 4; c++) begin
      step(1'b0, '0, 1'b0);
      n_checks++;
      if (obs() !== exp_vec) begin
        n_fail++; $display("FAIL random_drain cycle %0d: got %b expected %b", c, obs(), exp_vec);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    next_id  = 0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_reset_mid_word();
    test_stream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_tree_mlane_serializer.md
Name: conv_tree_mlane_serializer

Overview:
- Next-generation parallel-to-serial converter for the conv-tree serializer datapath.
- Accepts INPUTS_NUM-bit words over a valid/ready handshake and emits them over LANES parallel serial lanes, LANES bits per beat.
- Selectable MSB-first or LSB-first order per word; double-buffered so back-to-back words stream with no idle beats.
- Sits between the conv-tree output stage and the pad/serial link logic.

Parameters:
- INPUTS_NUM, 16, word width in bits; must be a multiple of LANES.
- LANES, 2, number of serial output lanes; INPUTS_NUM/LANES >= 2.

Ports:
- CLK  input  1  single clock; all state on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- PAR_IN  input  INPUTS_NUM  parallel word.
- PAR_VALID  input  1  PAR_IN holds a valid word.
- MSB_FIRST  input  1  order for the word offered with PAR_VALID; 1 = MSB first.
- PAR_READY  output  1  block can accept a word this cycle.
- SERIAL_OUT  output  LANES  current beat's bits.
- SERIAL_VALID  output  1  SERIAL_OUT carries word data.
- FRAME_START  output  1  high on the first beat of each word.

Behaviour:
- BEATS = INPUTS_NUM/LANES (+1 with PARITY_EN). Beat counter width is $clog2(BEATS).
- RESET low, async: all outputs 0; shift register, hold register and counter cleared; state IDLE.
- PAR_READY is registered. It rises on the first CLK edge after RESET release and thereafter equals "hold register empty".
- Accept: a word and its MSB_FIRST are captured on a rising edge with PAR_VALID && PAR_READY. PAR_IN is don't-care otherwise.
- Storage: hold register (1 word + mode bit) feeding a shift register.
  - Shift register empty, or on its last beat: loads from the hold register if full, else directly from an accepted word.
  - Otherwise the accepted word goes to the hold register.
- Latency: word accepted at edge t → beat 0 on SERIAL_OUT after edge t+1, with SERIAL_VALID=1 and FRAME_START=1.
- Beat slice:
  - Beat k, MSB_FIRST=1: word[INPUTS_NUM-1-k*LANES -: LANES].
  - Beat k, MSB_FIRST=0: word[k*LANES +: LANES].
  - Slice bit i drives SERIAL_OUT[i].
- FSM:
  - IDLE → SHIFT on load.
  - SHIFT: counter increments each beat. On the last beat, goes to SHIFT (counter 0, FRAME_START next) if a word is available that cycle, else IDLE.
- Streaming: with PAR_VALID held high, output is gapless. SERIAL_VALID stays 1 continuously and PAR_READY stays 1 except when the hold register is full.
- IDLE: SERIAL_VALID=0, FRAME_START=0, SERIAL_OUT=0.
- Simultaneous accept and last beat: the accepted word loads straight into the shift register; the hold register stays empty.
- Mid-word MSB_FIRST changes do not affect the word in flight.
- Reset mid-word: in-flight and held words are discarded. No partial output after release.

Optional Feature:
- Macro CONV_TREE_SER_PARITY_EN.
- Defined: after the last data beat, one extra beat with SERIAL_VALID=1, FRAME_START=0. SERIAL_OUT[i] is the even-parity bit (XOR) of all bits sent on lane i in that word. BEATS = INPUTS_NUM/LANES+1.
- Not defined: no parity beat; BEATS = INPUTS_NUM/LANES.

Decomposition:
- Package conv_tree_ser_pkg:
  - function for beat count;
  - state enum (IDLE, SHIFT);
  - elaboration-time check that INPUTS_NUM % LANES == 0.
- One sub-module: conv_tree_ser_hold_buf, a one-entry word + mode buffer with registered ready.

Test Plan (INPUTS_NUM=16, LANES=2):
- Reset: RESET=0 mid-stream → all outputs 0 immediately. After release, PAR_READY=1 one edge later.
- MSB first: 16'hC5AF, MSB_FIRST=1 → 8 beats 11,00,01,01,10,10,11,11. FRAME_START on beat 0 only. Then SERIAL_VALID=0.
- LSB first: 16'hC5AF, MSB_FIRST=0 → beats 11,11,10,10,01,01,00,11.
- Back-to-back: 16'hC5AF then 16'h0001 with PAR_VALID held high → 16 contiguous valid beats. FRAME_START on beats 0 and 8. PAR_READY drops while the hold register is full.
- Reset mid-word: assert RESET at beat 3 of 16'hC5AF → SERIAL_VALID=0 at once. No residual beats after release.
- PARITY_EN: 16'hC5AF MSB first → 8 data beats then parity beat 2'b11. Next word's FRAME_START follows the parity beat.
